pll_reset_sequencer: RTL and testbench

Controls the board PLL from its reference-clock domain. Sequences the PLL reset pulse and waits for lock with a timeout and bounded retries. Qualifies lock as stable before releasing the core reset, and re-sequences automatically if lock is lost. Sits between the top-level reset/refclk and the PLL wrapper; core_rst is re-synchronised into each PLL output domain by existing reset synchronisers.

---
 rtl/pll_seq_pkg.sv | 14 +
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 138 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

   localparam int unsigned LockLossW = 8;

   typedef enum logic [2:0] {
      StResetPll  = 3'd0,
      StWaitLock  = 3'd1,
      StStabilize = 3'd2,
      StRun       = 3'd3,
      StFault     = 3'd4
   } seq_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchroniser with asynchronous active-high clear.
module sync_2ff (
   input  logic clk_i,
   input  logic clr_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, sync_q;

   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for lock with timeout/retries, qualifies lock stability and
// holds core reset until the PLL is stable; re-sequences on lock loss.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 4,
   parameter int unsigned TMR_W         = 20
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 pll_locked,
   input  logic                 restart,
   output logic                 pll_rst,
   output logic                 core_rst,
   output logic                 ready,
   output logic                 fault,
   output logic [2:0]           state,
   output logic [LockLossW-1:0] lock_loss_cnt
);

   localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

   localparam logic [TMR_W-1:0]  RstLoad    = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LockLoad   = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  StableLoad = TMR_W'(STABLE_CYCLES - 1);
   localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRIES);

   logic                 locked_s;
   seq_state_e           state_q, state_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [RetryW-1:0]    retry_q, retry_d, retry_inc;
   logic [LockLossW-1:0] llc_q, llc_d;
   logic                 pll_rst_q, core_rst_q, ready_q, fault_q;
   logic                 tmr_zero;

   sync_2ff u_lock_sync (
      .clk_i (refclk),
      .clr_i (rst),
      .d_i   (pll_locked),
      .q_o   (locked_s)
   );

   assign tmr_zero  = (tmr_q == '0);
   assign retry_inc = retry_q + RetryW'(1);

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      retry_d = retry_q;
      llc_d   = llc_q;
      // restart overrides every state-local decision, including lock loss
      if (restart) begin
         state_d = StResetPll;
         tmr_d   = RstLoad;
         retry_d = '0;
      end else begin
         case (state_q)
            StResetPll: begin
               if (tmr_zero) begin
                  state_d = StWaitLock;
                  tmr_d   = LockLoad;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            StWaitLock: begin
               if (locked_s) begin
                  state_d = StStabilize;
                  tmr_d   = StableLoad;
               end else if (tmr_zero) begin
                  retry_d = retry_inc;
                  tmr_d   = RstLoad;
                  state_d = (retry_inc == RetryMax) ? StFault : StResetPll;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            StStabilize: begin
               if (!locked_s) begin
                  state_d = StWaitLock;
                  tmr_d   = LockLoad;
               end else if (tmr_zero) begin
                  state_d = StRun;
                  retry_d = '0;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            StRun: begin
               if (!locked_s) begin
                  state_d = StResetPll;
                  tmr_d   = RstLoad;
                  if (llc_q != '1) llc_d = llc_q + LockLossW'(1);
               end
            end
            StFault: ;
            default: begin
               state_d = StResetPll;
               tmr_d   = RstLoad;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q    <= StResetPll;
         tmr_q      <= RstLoad;
         retry_q    <= '0;
         llc_q      <= '0;
         pll_rst_q  <= 1'b1;
         core_rst_q <= 1'b1;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         retry_q    <= retry_d;
         llc_q      <= llc_d;
         pll_rst_q  <= (state_d == StResetPll) || (state_d == StFault);
         core_rst_q <= (state_d != StRun);
         ready_q    <= (state_d == StRun);
         fault_q    <= (state_d == StFault);
      end
   end

   assign pll_rst       = pll_rst_q;
   assign core_rst      = core_rst_q;
   assign ready         = ready_q;
   assign fault         = fault_q;
   assign state         = state_q;
   assign lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst, core_rst, ready, fault;
   logic [2:0] state;
   logic [7:0] lock_loss_cnt;

   int n_cmp = 0;
   int n_err = 0;

   pll_reset_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (32),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (2),
      .TMR_W         (20)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .restart       (restart),
      .pll_rst       (pll_rst),
      .core_rst      (core_rst),
      .ready         (ready),
      .fault         (fault),
      .state         (state),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] st, input int bound);
      int n = 0;
      while (state !== st && n < bound) begin
         tick();
         n++;
      end
      if (state !== st) check_eq(tag, 32'(state), 32'(st));
   endtask

   // Ticks until ready rises; returns the number of ticks taken (bound on expiry).
   task automatic ticks_to_ready(input int bound, output int n);
      n = 0;
      while (ready !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic ticks_while_pll_rst(input int bound, output int n);
      n = 0;
      while (pll_rst === 1'b1 && n < bound) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, m, hi, rises, first_fault;
      logic prev;

      // Reset state
      repeat (3) tick();
      check_eq("rst_state", 32'(state), 0);
      check_eq("rst_pll_rst", 32'(pll_rst), 1);
      check_eq("rst_core_rst", 32'(core_rst), 1);
      check_eq("rst_ready", 32'(ready), 0);
      check_eq("rst_fault", 32'(fault), 0);
      check_eq("rst_llc", 32'(lock_loss_cnt), 0);

      // Power-up sequence
      rst = 1'b0;
      ticks_while_pll_rst(20, n);
      check_eq("pwr_pll_rst_len", n, 4);
      check_eq("pwr_wait_state", 32'(state), 1);
      check_eq("pwr_wait_core_rst", 32'(core_rst), 1);
      repeat (10) tick();
      pll_locked = 1'b1;
      ticks_to_ready(40, n);
      check_eq("pwr_lock_to_ready", n, 11);
      check_eq("pwr_run_state", 32'(state), 3);
      check_eq("pwr_run_core_rst", 32'(core_rst), 0);
      check_eq("pwr_run_pll_rst", 32'(pll_rst), 0);

      // Lock loss in RUN: two sync cycles plus one FSM cycle
      pll_locked = 1'b0;
      tick();
      tick();
      check_eq("loss_still_run", 32'(state), 3);
      tick();
      check_eq("loss_state", 32'(state), 0);
      check_eq("loss_core_rst", 32'(core_rst), 1);
      check_eq("loss_pll_rst", 32'(pll_rst), 1);
      check_eq("loss_llc", 32'(lock_loss_cnt), 1);

      // Glitch in STABILIZE returns to WAIT_LOCK, then a full stable window
      pll_locked = 1'b1;
      wait_state("glitch_reach_stab", 3'd2, 20);
      repeat (3) tick();
      pll_locked = 1'b0;
      repeat (3) tick();
      check_eq("glitch_wait_state", 32'(state), 1);
      check_eq("glitch_core_rst", 32'(core_rst), 1);
      pll_locked = 1'b1;
      ticks_to_ready(40, n);
      check_eq("glitch_relock_to_ready", n, 11);

      // Restart coinciding with lock loss: restart wins, no count
      pll_locked = 1'b0;
      tick();
      tick();
      check_eq("rlos_still_run", 32'(state), 3);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check_eq("rlos_state", 32'(state), 0);
      check_eq("rlos_llc", 32'(lock_loss_cnt), 1);
      pll_locked = 1'b1;
      ticks_to_ready(40, n);
      check_eq("rlos_back_to_run", 32'(ready), 1);

      // Repeated lock losses saturate the counter
      for (int i = 1; i <= 300; i++) begin
         pll_locked = 1'b0;
         wait_state("sat_loss", 3'd0, 10);
         pll_locked = 1'b1;
         ticks_to_ready(40, n);
         if (i == 100) check_eq("sat_llc_101", 32'(lock_loss_cnt), 101);
      end
      check_eq("sat_llc_255", 32'(lock_loss_cnt), 255);

      // Timeout path: two attempts, then FAULT
      pll_locked = 1'b0;
      wait_state("to_reach_reset", 3'd0, 10);
      hi = 0;
      rises = 0;
      first_fault = -1;
      prev = 1'b1;
      for (int k = 0; k < 80; k++) begin
         if (pll_rst === 1'b1) hi++;
         if (pll_rst === 1'b1 && prev === 1'b0) rises++;
         if (state === 3'd4 && first_fault < 0) first_fault = k;
         prev = pll_rst;
         tick();
      end
      check_eq("to_pll_rst_high_cycles", hi, 16);
      check_eq("to_pll_rst_rises", rises, 2);
      check_eq("to_fault_entry", first_fault, 72);
      check_eq("to_fault_flag", 32'(fault), 1);
      check_eq("to_fault_pll_rst", 32'(pll_rst), 1);
      check_eq("to_fault_ready", 32'(ready), 0);

      // Restart out of FAULT
      pll_locked = 1'b1;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check_eq("rs_fault_clear", 32'(fault), 0);
      check_eq("rs_state", 32'(state), 0);
      ticks_while_pll_rst(20, n);
      check_eq("rs_pll_rst_len", n, 4);
      ticks_to_ready(40, m);
      check_eq("rs_to_ready", m, 9);
      check_eq("rs_llc_kept", 32'(lock_loss_cnt), 255);

      // Asynchronous reset mid-STABILIZE
      pll_locked = 1'b0;
      wait_state("ar_loss", 3'd0, 10);
      pll_locked = 1'b1;
      wait_state("ar_reach_stab", 3'd2, 20);
      #3 rst = 1'b1;
      #1;
      check_eq("ar_state", 32'(state), 0);
      check_eq("ar_pll_rst", 32'(pll_rst), 1);
      check_eq("ar_core_rst", 32'(core_rst), 1);
      check_eq("ar_ready", 32'(ready), 0);
      check_eq("ar_fault", 32'(fault), 0);
      check_eq("ar_llc", 32'(lock_loss_cnt), 0);
      tick();
      tick();
      rst = 1'b0;
      ticks_to_ready(40, n);
      check_eq("ar_release_to_ready", n, 13);
      check_eq("ar_run_state", 32'(state), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
